// File: rtl/sfp_norm_pkg.sv
// Shared types and width helpers for the row normaliser.
package sfp_norm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      OUT  = 2'd2
   } norm_state_t;

   // Width of an unsigned sum of COL absolute lane values, with one bit of headroom.
   function automatic int sum_w(input int col, input int bw_psum);
      return bw_psum + $clog2(col) + 1;
   endfunction

   // Signed quotient width: FRAC fraction bits, one integer bit and a sign bit.
   function automatic int qw(input int frac);
      return frac + 2;
   endfunction

endpackage

// File: rtl/sfp_norm_row_if.sv
// Row stream interface for sfp_norm_row. The partner-core sum signals exist
// only when SFP_NORM_EXT_SUM_EN is defined.
interface sfp_norm_row_if
   import sfp_norm_pkg::*;
#(
   parameter int COL     = 8,
   parameter int BW_PSUM = 20,
   parameter int FRAC    = 8
);
   localparam int SUM_W = sum_w(COL, BW_PSUM);
   localparam int QW    = qw(FRAC);

   logic                    in_valid;
   logic                    in_ready;
   logic [COL*BW_PSUM-1:0]  in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [COL*QW-1:0]       out_data;
`ifdef SFP_NORM_EXT_SUM_EN
   logic [SUM_W-1:0]        sum_out;
   logic                    sum_out_valid;
   logic [SUM_W-1:0]        sum_in;
   logic                    sum_in_valid;

   modport master (
      output in_valid, in_data, out_ready, sum_in, sum_in_valid,
      input  in_ready, out_valid, out_data, sum_out, sum_out_valid
   );
   modport slave (
      input  in_valid, in_data, out_ready, sum_in, sum_in_valid,
      output in_ready, out_valid, out_data, sum_out, sum_out_valid
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
`endif
endinterface

// File: rtl/sfp_div_seq.sv
// One-lane restoring divider: quo = sign(mag*2^FRAC / den), one quotient bit
// per cycle for FRAC+1 cycles after start. A zero denominator yields 0.
// The result register holds until clear so the parent can present it directly.
module sfp_div_seq #(
   parameter int SUM_W = 24,
   parameter int FRAC  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                clear,
   input  logic [SUM_W-1:0]    mag,
   input  logic                neg,
   input  logic [SUM_W-1:0]    den,
   output logic                done,
   output logic [FRAC+1:0]     quo
);
   localparam int QW = FRAC + 2;
   localparam int CW = $clog2(FRAC + 2);

   logic             active;
   logic [CW-1:0]    cnt;
   logic [SUM_W:0]   rem;
   logic [SUM_W-1:0] den_r;
   logic             neg_r;
   logic             den_zero;
   logic [FRAC-1:0]  q;

   logic             ge;
   logic [SUM_W-1:0] diff;
   logic [FRAC:0]    uq;
   logic [QW-1:0]    mag_q;

   // Trial subtraction for the current quotient bit and the assembled final quotient.
   always_comb begin
      ge    = rem >= {1'b0, den_r};
      diff  = rem[SUM_W-1:0] - den_r;
      uq    = {q, ge};
      mag_q = {1'b0, uq};
      done  = active && (cnt == CW'(FRAC));
   end

   // Iterate the long division; the last iteration writes the signed result.
   always_ff @(posedge clk) begin
      if (reset) begin
         active   <= 1'b0;
         cnt      <= '0;
         rem      <= '0;
         den_r    <= '0;
         neg_r    <= 1'b0;
         den_zero <= 1'b0;
         q        <= '0;
         quo      <= '0;
      end else if (start) begin
         active   <= 1'b1;
         cnt      <= '0;
         rem      <= {1'b0, mag};
         den_r    <= den;
         neg_r    <= neg;
         den_zero <= (den == '0);
         q        <= '0;
         quo      <= '0;
      end else if (active) begin
         rem <= ge ? {diff, 1'b0} : {rem[SUM_W-1:0], 1'b0};
         q   <= uq[FRAC-1:0];
         cnt <= cnt + 1'b1;
         if (done) begin
            active <= 1'b0;
            quo    <= den_zero ? '0 : (neg_r ? -mag_q : mag_q);
         end
      end else if (clear) begin
         quo <= '0;
      end
   end

endmodule

// File: rtl/sfp_norm_row.sv
// Row normaliser: buffers signed psum rows with their absolute sums in a FIFO,
// then divides every lane magnitude by the row sum into a signed fixed-point
// quotient. Define SFP_NORM_EXT_SUM_EN to add the partner-core sum to the
// denominator and expose the head-row sum.
module sfp_norm_row
   import sfp_norm_pkg::*;
#(
   parameter int COL     = 8,
   parameter int BW_PSUM = 20,
   parameter int DEPTH   = 16,
   parameter int FRAC    = 8
) (
   input  logic           clk,
   input  logic           reset,
   sfp_norm_row_if.slave  bus
);
   localparam int SUM_W = sum_w(COL, BW_PSUM);
   localparam int QW    = qw(FRAC);
   localparam int AW    = $clog2(DEPTH);

   logic [COL*BW_PSUM-1:0] mem_row [DEPTH];
   logic [SUM_W-1:0]       mem_sum [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [AW:0]            count;

   norm_state_t            state;
   logic                   out_valid_r;

   logic                   push;
   logic                   pop;
   logic                   handshake;
   logic                   not_empty;
   logic [SUM_W-1:0]       in_mag [COL];
   logic [SUM_W-1:0]       in_sum;
   logic [COL*BW_PSUM-1:0] head_row;
   logic [SUM_W-1:0]       head_sum;
   logic [SUM_W-1:0]       den;
   logic [COL-1:0]         lane_done;
   logic [COL*QW-1:0]      out_data_w;

   assign not_empty     = (count != '0);
   assign bus.in_ready  = (count != (AW+1)'(DEPTH));
   assign push          = bus.in_valid && bus.in_ready;
   assign handshake     = (state == OUT) && bus.out_ready;
   assign head_row      = mem_row[rd_ptr];
   assign head_sum      = mem_sum[rd_ptr];
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_w;

`ifdef SFP_NORM_EXT_SUM_EN
   assign pop               = (state == IDLE) && not_empty && bus.sum_in_valid;
   assign den               = head_sum + bus.sum_in;
   assign bus.sum_out       = not_empty ? head_sum : '0;
   assign bus.sum_out_valid = not_empty;
`else
   assign pop = (state == IDLE) && not_empty;
   assign den = head_sum;
`endif

   for (genvar i = 0; i < COL; i++) begin : g_lane
      logic signed [BW_PSUM-1:0] in_x;
      logic signed [SUM_W-1:0]   in_ext;
      logic signed [BW_PSUM-1:0] hd_x;
      logic signed [SUM_W-1:0]   hd_ext;
      logic [SUM_W-1:0]          hd_mag;

      assign in_x      = bus.in_data[i*BW_PSUM +: BW_PSUM];
      assign in_ext    = SUM_W'(in_x);
      assign in_mag[i] = in_x[BW_PSUM-1] ? -in_ext : in_ext;

      assign hd_x   = head_row[i*BW_PSUM +: BW_PSUM];
      assign hd_ext = SUM_W'(hd_x);
      assign hd_mag = hd_x[BW_PSUM-1] ? -hd_ext : hd_ext;

      sfp_div_seq #(
         .SUM_W (SUM_W),
         .FRAC  (FRAC)
      ) u_div (
         .clk   (clk),
         .reset (reset),
         .start (pop),
         .clear (handshake),
         .mag   (hd_mag),
         .neg   (hd_x[BW_PSUM-1]),
         .den   (den),
         .done  (lane_done[i]),
         .quo   (out_data_w[i*QW +: QW])
      );
   end

   // Absolute sum of the incoming row, stored alongside it in the FIFO.
   always_comb begin
      in_sum = '0;
      for (int i = 0; i < COL; i++) begin
         in_sum = in_sum + in_mag[i];
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_row[wr_ptr] <= bus.in_data;
         mem_sum[wr_ptr] <= in_sum;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Control FSM: pop a row, wait for all lane dividers, hold the result until taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (pop) state <= DIV;
            DIV: if (&lane_done) begin
               state       <= OUT;
               out_valid_r <= 1'b1;
            end
            OUT: if (bus.out_ready) begin
               state       <= IDLE;
               out_valid_r <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfp_norm_row.sv
// Directed self-checking bench for sfp_norm_row at default parameters.
// The partner-sum scenario is compiled in when SFP_NORM_EXT_SUM_EN is defined.
module tb_sfp_norm_row
   import sfp_norm_pkg::*;
;
   localparam int COL   = 8;
   localparam int BW    = 20;
   localparam int DEPTH = 16;
   localparam int FRAC  = 8;
   localparam int QW    = qw(FRAC);

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   sfp_norm_row_if #(.COL(COL), .BW_PSUM(BW), .FRAC(FRAC)) bus ();

   sfp_norm_row #(
      .COL     (COL),
      .BW_PSUM (BW),
      .DEPTH   (DEPTH),
      .FRAC    (FRAC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [COL*BW-1:0] packRow(input int a, input int b, input int c, input int others);
      logic [COL*BW-1:0] r;
      int v;
      r = '0;
      for (int i = 0; i < COL; i++) begin
         v = (i == 0) ? a : (i == 1) ? b : (i == 2) ? c : others;
         r[i*BW +: BW] = BW'(v);
      end
      return r;
   endfunction

   function automatic logic [QW-1:0] qv(input int v);
      return QW'(v);
   endfunction

   task automatic applyStimulus(input logic [COL*BW-1:0] row);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = row;
      n = 0;
      while (!bus.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) checkOutput("push_timeout", 0, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic waitOut(output int cycles);
      cycles = 0;
      while (cycles < 40) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (bus.out_valid) break;
         if (cycles == 5) checkOutput("data_zero_while_busy", bus.out_data, 0);
      end
      if (!bus.out_valid) checkOutput("out_valid_timeout", 0, 1);
   endtask

   task automatic checkLanes(input string tag, input int e0, input int e1, input int e2, input int eo);
      int e;
      for (int i = 0; i < COL; i++) begin
         e = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : eo;
         checkOutput($sformatf("%s_lane%0d", tag, i), bus.out_data[i*QW +: QW], qv(e));
      end
   endtask

   task automatic runRow(input string tag, input logic [COL*BW-1:0] row,
                         input int e0, input int e1, input int e2, input int eo);
      int cyc;
      applyStimulus(row);
      waitOut(cyc);
      checkOutput({tag, "_latency"}, cyc, 10);
      checkLanes(tag, e0, e1, e2, eo);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_valid_drop"}, bus.out_valid, 0);
      checkOutput({tag, "_data_clear"}, bus.out_data, 0);
      checkOutput({tag, "_idle"}, dut.state, IDLE);
   endtask

   initial begin
      int accepted;
      logic rdy;
      int n;
      int cyc;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
`ifdef SFP_NORM_EXT_SUM_EN
      bus.sum_in       = '0;
      bus.sum_in_valid = 1'b1;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_out_data", bus.out_data, 0);
      checkOutput("rst_in_ready", bus.in_ready, 1);
      checkOutput("rst_fifo_empty", dut.count, 0);
      checkOutput("rst_state", dut.state, IDLE);
`ifdef SFP_NORM_EXT_SUM_EN
      checkOutput("rst_sum_out", bus.sum_out, 0);
      checkOutput("rst_sum_out_valid", bus.sum_out_valid, 0);
`endif
      reset = 1'b0;

      runRow("ones", packRow(1, 1, 1, 1), 32, 32, 32, 32);
      runRow("pm4", packRow(-4, 4, 0, 0), -128, 128, 0, 0);
      runRow("zeros", packRow(0, 0, 0, 0), 0, 0, 0, 0);
      runRow("full_scale", packRow(5, 0, 0, 0), 256, 0, 0, 0);
      runRow("mixed", packRow(-3, 1, 0, 0), -192, 64, 0, 0);
      runRow("thirds", packRow(1, 1, 1, 0), 85, 85, 85, 0);

      // Back-pressure: hold in_valid with out_ready low until the FIFO fills.
      @(negedge clk);
      bus.out_ready = 1'b0;
      accepted = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = packRow(accepted + 1, 1, 0, 0);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) accepted++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("bp_accepted", accepted, 17);
      checkOutput("bp_in_ready_low", bus.in_ready, 0);
      checkOutput("bp_fifo_full", dut.count, DEPTH);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         n = 0;
         while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         checkOutput($sformatf("drain%0d_valid", k), bus.out_valid, 1);
         checkOutput($sformatf("drain%0d_lane0", k), bus.out_data[0 +: QW], qv(((k + 1) * 256) / (k + 2)));
         checkOutput($sformatf("drain%0d_lane1", k), bus.out_data[QW +: QW], qv(256 / (k + 2)));
         @(posedge clk);
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      checkOutput("drain_fifo_empty", dut.count, 0);
      checkOutput("drain_in_ready", bus.in_ready, 1);
      checkOutput("drain_idle", dut.state, IDLE);

`ifdef SFP_NORM_EXT_SUM_EN
      // Partner sum: no pop without sum_in_valid, then D = 8 + 8.
      @(negedge clk);
      bus.sum_in_valid = 1'b0;
      bus.sum_in       = 24'd8;
      applyStimulus(packRow(1, 1, 1, 1));
      repeat (5) @(negedge clk);
      checkOutput("ext_no_pop_state", dut.state, IDLE);
      checkOutput("ext_no_pop_count", dut.count, 1);
      checkOutput("ext_sum_out", bus.sum_out, 8);
      checkOutput("ext_sum_out_valid", bus.sum_out_valid, 1);
      bus.sum_in_valid = 1'b1;
      waitOut(cyc);
      checkLanes("ext", 16, 16, 16, 16);
      @(posedge clk);
      @(negedge clk);
      bus.sum_in = '0;
      checkOutput("ext_idle", dut.state, IDLE);
`endif

      // Reset in the middle of a division with a second row queued.
      applyStimulus(packRow(1, 1, 1, 1));
      applyStimulus(packRow(2, 2, 2, 2));
      repeat (3) @(negedge clk);
      checkOutput("abort_in_div", dut.state, DIV);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_out_valid", bus.out_valid, 0);
      checkOutput("abort_in_ready", bus.in_ready, 1);
      checkOutput("abort_fifo_empty", dut.count, 0);
      checkOutput("abort_state", dut.state, IDLE);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort_no_output", bus.out_valid, 0);
      runRow("post_abort", packRow(1, 1, 1, 1), 32, 32, 32, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
